// File: rtl/i2c_resp_pkg.sv
// Shared types for the I2C responder: bus direction and FSM states.
// Imported by the line synchronizer and the responder top.
package i2c_resp_pkg;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_resp_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_resp_slave_line_sync.sv
// Synchronizes scl/sda into clk_i and derives scl edges and START/STOP.
// All pulses are single-cycle and come from registered samples only.
module i2c_line_sync
  import i2c_resp_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;
  logic                   scl_s;
  logic                   sda_s;

  // Reset to the idle bus level so release never fakes an edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign sda_s_o    = sda_s;
  assign scl_rise_o = scl_s & ~scl_dly_q;
  assign scl_fall_o = ~scl_s & scl_dly_q;
  assign start_o    = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_o     = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

endmodule

// File: rtl/i2c_resp_slave.sv
// I2C target at a fixed address backed by a wrapping byte buffer.
// Drives sda open-drain on synchronized scl falls; never touches scl.
module i2c_resp_slave
  import i2c_resp_pkg::*;
#(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22,
  parameter int                        MEM_DEPTH      = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic                      busy_o,
  output logic                      start_det_o,
  output logic                      stop_det_o,
  output logic                      wr_strobe_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      rd_strobe_o,
  output logic                      nak_det_o
);

  localparam int DW = I2C_DATA_WIDTH;
  localparam int PW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
  localparam logic [CW-1:0] FULL = CW'(DW);

  logic sda_s, rise, fall, start, stop;

  i2c_line_sync u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_s_o    (sda_s),
    .scl_rise_o (rise),
    .scl_fall_o (fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  i2c_resp_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  i2c_op_t         rw_q, rw_d;
  logic            sda_q, sda_d;
  logic            wr_stb_q, wr_stb_d;
  logic            rd_stb_q, rd_stb_d;
  logic            nak_q, nak_d;
  logic            start_q, start_d;
  logic            stop_q, stop_d;
  logic            mem_we;
  logic [DW-1:0]   mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      sh_q      <= '0;
      wr_data_q <= '0;
      rw_q      <= WRITE;
      sda_q     <= 1'b1;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      nak_q     <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      sh_q      <= sh_d;
      wr_data_q <= wr_data_d;
      rw_q      <= rw_d;
      sda_q     <= sda_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      nak_q     <= nak_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
    end
  end

  // Buffer is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) begin
      mem_q[ptr_q] <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    sh_d      = sh_q;
    wr_data_d = wr_data_q;
    rw_d      = rw_q;
    sda_d     = sda_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    nak_d     = 1'b0;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    mem_we    = 1'b0;
    if (stop) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      stop_d  = 1'b1;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      ptr_d   = '0;
      sda_d   = 1'b1;
      start_d = 1'b1;
    end else if (rise) begin
      unique case (state_q)
        ADDR: begin
          sh_d  = {sh_q[DW-2:0], sda_s};
          cnt_d = cnt_q + 1'b1;
        end
        WR_BYTE: begin
          sh_d  = {sh_q[DW-2:0], sda_s};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            mem_we    = 1'b1;
            wr_data_d = sh_d;
            wr_stb_d  = 1'b1;
            ptr_d     = ptr_q + 1'b1;
          end
        end
        RD_ACK: begin
          rd_stb_d = 1'b1;
          if (sda_s) begin
            nak_d   = 1'b1;
            state_d = IGNORE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end else if (fall) begin
      unique case (state_q)
        ADDR: begin
          if (cnt_q == FULL) begin
            if (sh_q[DW-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
              sda_d   = 1'b0;
              rw_d    = i2c_op_t'(sh_q[0]);
              state_d = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK, RD_ACK: begin
          if (state_q == RD_ACK || rw_q == READ) begin
            sh_d    = mem_q[ptr_q];
            sda_d   = mem_q[ptr_q][DW-1];
            cnt_d   = CW'(1);
            state_d = RD_BYTE;
          end else begin
            sda_d   = 1'b1;
            cnt_d   = '0;
            state_d = WR_BYTE;
          end
        end
        WR_BYTE: begin
          if (cnt_q == FULL) begin
            sda_d   = 1'b0;
            state_d = WR_ACK;
          end
        end
        WR_ACK: begin
          sda_d   = 1'b1;
          cnt_d   = '0;
          state_d = WR_BYTE;
        end
        RD_BYTE: begin
          if (cnt_q == FULL) begin
            sda_d   = 1'b1;
            state_d = RD_ACK;
          end else begin
            sh_d  = sh_q << 1;
            sda_d = sh_q[DW-2];
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sda_o       = sda_q;
    busy_o      = state_q inside {ADDR_ACK, WR_BYTE, WR_ACK,
                                  RD_BYTE, RD_ACK};
    start_det_o = start_q;
    stop_det_o  = stop_q;
    wr_strobe_o = wr_stb_q;
    wr_data_o   = wr_data_q;
    rd_strobe_o = rd_stb_q;
    nak_det_o   = nak_q;
  end

endmodule

// File: tb/tb_i2c_resp_slave.sv
// Bench for i2c_resp_slave: bit-banged bus master plus a buffer model
// indexed from zero at every START.
module tb_i2c_resp_slave;

  localparam int H = 7;
  localparam int DEPTH = 64;
  localparam logic [6:0] SA = 7'h22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_o, busy, st_det, sp_det, wr_stb, rd_stb, nak;
  logic [7:0] wr_data;
  wire sda_bus;
  assign sda_bus = sda_m & sda_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] mem_m [DEPTH];
  logic [7:0] wbuf[$];
  logic [7:0] wq[$];
  int n_rd, n_nak, n_start, n_stop, n_low, n_busy;

  always #5 clk = ~clk;

  i2c_resp_slave dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .scl_i       (scl),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .busy_o      (busy),
    .start_det_o (st_det),
    .stop_det_o  (sp_det),
    .wr_strobe_o (wr_stb),
    .wr_data_o   (wr_data),
    .rd_strobe_o (rd_stb),
    .nak_det_o   (nak)
  );

  always @(negedge clk) begin
    if (wr_stb) wq.push_back(wr_data);
    if (rd_stb) n_rd++;
    if (nak) n_nak++;
    if (st_det) n_start++;
    if (sp_det) n_stop++;
    if (!sda_o) n_low++;
    if (busy) n_busy++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    wq.delete();
    n_rd = 0; n_nak = 0; n_start = 0;
    n_stop = 0; n_low = 0; n_busy = 0;
  endtask

  task automatic bit_x(input logic b, output logic r);
    sda_m = b; w(H);
    scl = 1'b1; w(H);
    r = sda_bus;
    scl = 1'b0; w(2);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; w(H);
    scl = 1'b1; w(H);
    sda_m = 1'b0; w(H);
    scl = 1'b0; w(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; w(H);
    scl = 1'b1; w(H);
    sda_m = 1'b1; w(H);
  endtask

  task automatic byte_w(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic byte_r(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    bit_x(mack, r);
  endtask

  // Writes wbuf from pointer 0; model tracks what the buffer must hold
  task automatic wr_xfer(input logic do_stop);
    logic a;
    int nk = 0;
    wq.delete();
    i2c_start();
    byte_w({SA, 1'b0}, a);
    check("wr_addr_ack", 32'(a), 0);
    check("wr_busy", 32'(busy), 1);
    foreach (wbuf[i]) begin
      byte_w(wbuf[i], a);
      if (a) nk++;
      mem_m[i % DEPTH] = wbuf[i];
    end
    check("wr_naks", nk, 0);
    check("wr_strobes", wq.size(), wbuf.size());
    foreach (wbuf[i]) begin
      check("wr_data", (i < wq.size()) ? 32'(wq[i]) : 32'hDEAD,
            32'(wbuf[i]));
    end
    if (do_stop) begin
      i2c_stop();
      check("wr_busy_end", 32'(busy), 0);
    end
  endtask

  // n bytes: ACK all but the last, NAK the last, then STOP
  task automatic rd_xfer(input int n);
    logic a;
    logic [7:0] d;
    int r0 = n_rd;
    int k0 = n_nak;
    i2c_start();
    byte_w({SA, 1'b1}, a);
    check("rd_addr_ack", 32'(a), 0);
    for (int k = 0; k < n; k++) begin
      byte_r(k == n - 1, d);
      check("rd_data", 32'(d), 32'(mem_m[k % DEPTH]));
    end
    i2c_stop();
    check("rd_strobes", n_rd - r0, n);
    check("rd_naks", n_nak - k0, 1);
    check("rd_busy_end", 32'(busy), 0);
  endtask

  initial begin
    logic a;
    logic [6:0] ad;
    int t;
    clr();
    rst = 1'b1; w(3);
    check("rst_sda", 32'(sda_o), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_pulses",
          {26'd0, st_det, sp_det, wr_stb, rd_stb, nak, 1'b0}, 0);
    rst = 1'b0; w(4);

    clr();
    wbuf.delete();
    for (int i = 0; i < 32; i++) wbuf.push_back(8'(i));
    wr_xfer(1'b1);
    check("wr_stop_det", n_stop, 1);
    check("wr_start_det", n_start, 1);

    clr();
    rd_xfer(32);

    clr();
    ad = 7'($urandom_range(0, 127));
    if (ad == SA) ad = ~SA;
    i2c_start();
    byte_w({ad, 1'b0}, a);
    check("mis_addr_nak", 32'(a), 1);
    byte_w(8'($urandom), a);
    i2c_stop();
    check("mis_sda_low", n_low, 0);
    check("mis_busy", n_busy, 0);
    check("mis_strobes", wq.size(), 0);

    clr();
    wbuf.delete();
    wbuf.push_back(8'($urandom));
    wr_xfer(1'b0);
    rd_xfer(1);
    check("sr_starts", n_start, 2);

    clr();
    wbuf.delete();
    for (int i = 0; i < 65; i++) wbuf.push_back(8'($urandom));
    wr_xfer(1'b1);
    rd_xfer(65);

    for (int it = 0; it < 3; it++) begin
      clr();
      wbuf.delete();
      t = $urandom_range(1, 16);
      for (int i = 0; i < t; i++) wbuf.push_back(8'($urandom));
      wr_xfer(1'b1);
      rd_xfer($urandom_range(1, 20));
    end

    clr();
    wbuf.delete();
    wbuf.push_back(8'($urandom) & 8'h7F);
    wr_xfer(1'b1);
    i2c_start();
    byte_w({SA, 1'b1}, a);
    t = 0;
    while (sda_o !== 1'b0 && t < 40) begin
      w(1);
      t++;
    end
    check("rrst_drive_low", 32'(sda_o), 0);
    check("rrst_busy_pre", 32'(busy), 1);
    rst = 1'b1; w(1);
    check("rrst_sda_rel", 32'(sda_o), 1);
    check("rrst_busy", 32'(busy), 0);
    rst = 1'b0;
    sda_m = 1'b1; w(H);
    scl = 1'b1; w(H);
    rd_xfer(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_resp_slave.md
Name: i2c_resp_slave

Overview:
Synthesizable I2C target (responder) that answers the iicmb_m_wb controller on one I2C bus, and serves as a reusable RTL slave model in benches. It oversamples scl/sda on the system clock, detects START/Sr/STOP, and matches a fixed 7-bit address. It ACKs write bytes into an internal byte buffer and returns buffer bytes on reads. It is open-drain on sda only and never stretches scl.

Parameters:
I2C_ADDR_WIDTH, 7, address width
I2C_DATA_WIDTH, 8, data byte width
SLAVE_ADDR, 7'h22, address this target responds to
MEM_DEPTH, 64, buffer entries (power of 2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active high
scl_i  in  1  I2C clock as seen on bus
sda_i  in  1  I2C data as seen on bus
sda_o  out  1  open-drain data drive; 0 = pull low, 1 = release
busy_o  out  1  high between an addressed START and the following STOP/Sr/NAK
start_det_o  out  1  1-cycle pulse on START or repeated START
stop_det_o  out  1  1-cycle pulse on STOP
wr_strobe_o  out  1  1-cycle pulse when a written byte is stored
wr_data_o  out  I2C_DATA_WIDTH  byte stored at the last wr_strobe_o
rd_strobe_o  out  1  1-cycle pulse when a read byte is ACKed or NAKed by the master
nak_det_o  out  1  1-cycle pulse when the master NAKs a read byte

Behaviour:
- Reset (rst_i sync, active high), next edge: sda_o=1, all pulses 0, busy_o=0, wr_data_o=0, state IDLE, pointer 0. Buffer contents are not reset. Reset mid-transfer releases sda within 1 clk.
- Input path: 2-flop synchronizer on scl_i/sda_i, plus 1 delay flop for edge detect.
  - START: sda fall while scl high. STOP: sda rise while scl high.
  - Bits are sampled on the synchronized scl rise. sda_o changes only on the synchronized scl fall.
  - Detection latency is 3 clk. Legal only when SCL high/low phases are ≥ 6 clk each.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- START/Sr in any state (including IDLE and IGNORE) → ADDR, bit count 0, pointer 0, start_det_o pulse.
- STOP in any state → IDLE, sda_o=1, busy_o=0, stop_det_o pulse.
- ADDR: shift 8 bits MSB first (7 addr + R/W).
  - On match, the 8th-bit fall drives sda_o=0 → ADDR_ACK, and busy_o=1.
  - On mismatch → IGNORE with sda released.
- ADDR_ACK, next scl fall:
  - W=0: release sda → WR_BYTE.
  - R=1: load mem[ptr] and drive its MSB → RD_BYTE.
- WR_BYTE: sample 8 bits. At the 8th rise: mem[ptr]<=byte, wr_data_o<=byte, wr_strobe_o pulse, ptr<=ptr+1 mod MEM_DEPTH. The following fall drives ACK → WR_ACK; the next fall releases sda → WR_BYTE.
- RD_BYTE: shift out on each fall. After the 8th bit's fall, release sda → RD_ACK.
- RD_ACK, master ack sampled on the rise (rd_strobe_o pulse):
  - 0 (ACK): ptr++ mod MEM_DEPTH, load next byte; the next fall drives its MSB → RD_BYTE.
  - 1 (NAK): nak_det_o pulse, busy_o=0 → IGNORE.
- Pointer wraps MEM_DEPTH-1 → 0 silently, for both reads and writes.
- START and STOP in the same sampled window cannot occur (they are mutually exclusive sda edges). A STOP that arrives before an ACK completes discards nothing already stored.
- scl_o does not exist; the target never drives scl.

Decomposition:
- Package i2c_resp_pkg:
  - typedef enum i2c_op_t {WRITE=0, READ=1}
  - typedef enum i2c_resp_state_t (the 8 states above)
  - localparam SYNC_STAGES=2
- Sub-module i2c_line_sync: synchronizers, edge detect, and start/stop/scl_rise/scl_fall pulses (~50 lines).
- Top holds the FSM, shift register, bit counter, pointer and buffer.

Test Plan:
- Bus hookup: DUT scl/sda bus with pull-up wire; sda = sda_o AND DUT sda_o.
- Write: Set Bus 0, START, addr 0x44, write bytes 0x00..0x1F, STOP → 32 wr_strobe_o pulses with wr_data_o 0..31, every byte ACKed (CMDR DON set, NAK clear), stop_det_o pulse, busy_o low.
- Readback: START, 0x45, 31 read-with-ACK plus 1 read-with-NAK, STOP → DPR returns 0x00..0x1F, 32 rd_strobe_o pulses, nak_det_o pulses once at byte 32.
- Address mismatch: START, 0x88 write → sda never pulled low, CMDR reports NAK, busy_o stays 0.
- Repeated start: START, 0x44, write 0xA5, Sr, 0x45, read-with-NAK → start_det_o pulses twice, mem[0]=0xA5, read returns 0xA5.
- Wrap: write 65 bytes 0..64 → mem[0]=64, then a 65-byte read returns 64,1,2,…,63,64.
- Reset mid-read: assert rst_i while sda_o=0 in RD_BYTE → sda_o=1 next clk, FSM IDLE, the next START/0x45 read returns mem[0].
